// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART transmit and receive blocks.
//   - uart_tx_state_t : transmitter frame state
//   - clks_per_bit()  : baud divider ratio, integer-truncated
//   - UART_DATA_BITS  : payload bits per frame
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  // Truncating divide so TX and RX agree on the same bit period.
  function automatic int clks_per_bit(input int clockRate, input int baudRate);
    return clockRate / baudRate;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo
//   Small synchronous byte FIFO with combinational read of the head entry.
//   Ports:
//     clk, reset      : clock, async active-high reset (empties the FIFO)
//     push, din       : write din when push && !full
//     pop, dout       : dout is the head entry; pop advances it when !empty
//     full, empty     : decoded from the registered occupancy count
module byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic [UART_DATA_BITS-1:0] din,
  output logic [UART_DATA_BITS-1:0] dout,
  output logic                      full,
  output logic                      empty
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  logic [UART_DATA_BITS-1:0] r_mem [DEPTH];
  logic [AW-1:0]             r_wr_ptr;
  logic [AW-1:0]             r_rd_ptr;
  logic [AW:0]               r_count;
  logic                      w_push;
  logic                      w_pop;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Pointers are exactly log2(DEPTH) wide, so wrap is the natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: occupancy is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = (r_count == (AW+1)'(DEPTH));
  assign empty = (r_count == '0);

endmodule

// File: rtl/uart_byte_tx.sv
// uart_byte_tx
//   UART transmitter: byte FIFO in front of a start/8 data/stop serialiser,
//   LSB first, with configurable 1 or 2 stop bits and no gap between queued
//   frames.
//   Ports:
//     clk         : system clock
//     reset       : async active-high; line goes idle-high immediately
//     data        : byte to send, taken when dataIsValid && ready
//     dataIsValid : push strobe
//     ready       : FIFO has room
//     tx          : serial line (registered, idle high)
//     idle        : FIFO empty and no frame in flight (registered)
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLOCK_RATE = 100_000,
  parameter int BAUD_RATE  = 9600,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [UART_DATA_BITS-1:0] data,
  input  logic                      dataIsValid,
  output logic                      ready,
  output logic                      tx,
  output logic                      idle
);

  localparam int CPB       = clks_per_bit(CLOCK_RATE, BAUD_RATE);
  localparam int STOP_CLKS = STOP_BITS * CPB;
  localparam int TW        = (STOP_CLKS > 2) ? $clog2(STOP_CLKS) : 1;

  localparam logic [TW-1:0] BIT_LAST  = TW'(CPB - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(STOP_CLKS - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(UART_DATA_BITS - 1);

  generate
    if (CPB < 2) begin : g_bad_divider
      $error("uart_byte_tx: CLOCK_RATE/BAUD_RATE must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_byte_tx: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_byte_tx: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  uart_tx_state_t            r_state;
  uart_tx_state_t            w_state_nxt;
  logic [TW-1:0]             r_timer;
  logic [TW-1:0]             w_timer_nxt;
  logic [2:0]                r_bit_idx;
  logic [2:0]                w_bit_idx_nxt;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] w_shift_nxt;
  logic                      r_tx;
  logic                      w_tx_nxt;
  logic                      r_idle;

  logic                      w_push;
  logic                      w_pop;
  logic                      w_full;
  logic                      w_empty;
  logic [UART_DATA_BITS-1:0] w_head;

  assign w_push = dataIsValid && !w_full;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (data),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  // Next-state and line level. The line value is a function of the current
  // state and is registered, so tx trails the state by one cycle; every bit
  // still lasts exactly CPB cycles.
  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer + TW'(1);
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_pop         = 1'b0;
    w_tx_nxt      = 1'b1;

    case (r_state)
      IDLE: begin
        w_timer_nxt = '0;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_state_nxt = START;
        end
      end

      START: begin
        w_tx_nxt = 1'b0;
        if (r_timer == BIT_LAST) begin
          w_timer_nxt   = '0;
          w_bit_idx_nxt = '0;
          w_state_nxt   = DATA;
        end
      end

      DATA: begin
        w_tx_nxt = r_shift[0];
        if (r_timer == BIT_LAST) begin
          w_timer_nxt = '0;
          w_shift_nxt = r_shift >> 1;
          if (r_bit_idx == IDX_LAST) begin
            w_state_nxt = STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end

      STOP: begin
        w_tx_nxt = 1'b1;
        if (r_timer == STOP_LAST) begin
          w_timer_nxt = '0;
          // Chain straight into the next start bit when something is queued.
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_state_nxt = START;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_timer_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_timer   <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_idle    <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_tx      <= w_tx_nxt;
      r_idle    <= (r_state == IDLE) && w_empty;
    end
  end

  assign ready = !w_full;
  assign tx    = r_tx;
  assign idle  = r_idle;

endmodule

// File: tb/tb_uart_byte_tx.sv
module tb_uart_byte_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       dataIsValid = 1'b0;
  logic [7:0] data = 8'h00;
  logic [2:0] tx_w;
  logic [2:0] idle_w;
  logic [2:0] ready_w;
  logic       tx0;
  logic       rst_done = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  assign tx0 = tx_w[0];

  // 0: defaults (10 clk/bit, 1 stop). 1: 2 stop bits. 2: 5 clk/bit.
  uart_byte_tx #(.CLOCK_RATE(100_000), .BAUD_RATE(9600), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .reset(reset), .data(data), .dataIsValid(dataIsValid),
    .ready(ready_w[0]), .tx(tx_w[0]), .idle(idle_w[0]));
  uart_byte_tx #(.CLOCK_RATE(100_000), .BAUD_RATE(9600), .STOP_BITS(2), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .reset(reset), .data(data), .dataIsValid(dataIsValid),
    .ready(ready_w[1]), .tx(tx_w[1]), .idle(idle_w[1]));
  uart_byte_tx #(.CLOCK_RATE(50_000), .BAUD_RATE(9600), .STOP_BITS(1), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .reset(reset), .data(data), .dataIsValid(dataIsValid),
    .ready(ready_w[2]), .tx(tx_w[2]), .idle(idle_w[2]));

  typedef struct {
    logic [7:0] din;
    logic [9:0] frame;  // slot 0 = start bit ... slot 9 = stop bit
  } vec_t;

  vec_t       tbl [8];
  logic [9:0] fq [$];    // expected frames for the waveform check
  logic [7:0] rxq [$];   // bytes recovered by the line decoder
  logic [7:0] sent [$];
  logic [7:0] rx_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] frame_of(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  task automatic push1(input logic [7:0] b);
    data = b;
    dataIsValid = 1'b1;
    tick();
    dataIsValid = 1'b0;
  endtask

  // Called just after the edge on which the first start bit should appear.
  // Walks every cycle of the queued frames against the ideal line waveform.
  task automatic check_wave(input int d, input int cpb, input int sb,
                            input int push_at, input logic [7:0] pb);
    int L, total, f, s;
    logic e;
    L = (9 + sb) * cpb;
    total = fq.size() * L;
    for (int k = 0; k < total; k++) begin
      f = k / L;
      s = (k % L) / cpb;
      e = (s <= 9) ? fq[f][s] : 1'b1;
      chk($sformatf("tx d%0d cyc%0d", d, k), {31'd0, tx_w[d]}, {31'd0, e});
      if (k == total - 1) chk($sformatf("idle_in_stop d%0d", d), {31'd0, idle_w[d]}, 32'd0);
      if (k == push_at) begin
        data = pb;
        dataIsValid = 1'b1;
      end
      tick();
      if (k == push_at) dataIsValid = 1'b0;
    end
    chk($sformatf("tx_after d%0d", d), {31'd0, tx_w[d]}, 32'd1);
    chk($sformatf("idle_rise d%0d", d), {31'd0, idle_w[d]}, 32'd1);
  endtask

  task automatic wait_all_idle(input int budget);
    int n;
    n = 0;
    while (idle_w !== 3'b111 && n < budget) begin
      tick();
      n++;
    end
    chk("idle_wait", {29'd0, idle_w}, 32'd7);
    repeat (3) tick();
  endtask

  task automatic chk_rx(input string name);
    chk({name, "_count"}, rxq.size(), sent.size());
    for (int i = 0; i < sent.size() && i < rxq.size(); i++)
      chk($sformatf("%s_byte%0d", name, i), {24'd0, rxq[i]}, {24'd0, sent[i]});
  endtask

  // Line receiver for dut0: samples mid-bit, 10 clocks per bit.
  initial begin
    wait (rst_done);
    forever begin
      @(negedge tx0);
      repeat (5) @(posedge clk);
      #1;
      if (tx0 == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (10) @(posedge clk);
          #1;
          rx_b[i] = tx0;
        end
        repeat (10) @(posedge clk);
        #1;
        chk("rx_stop_bit", {31'd0, tx0}, 32'd1);
        rxq.push_back(rx_b);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'h44, 10'b1010001000};
    tbl[1] = '{8'h11, 10'b1000100010};
    tbl[2] = '{8'h22, 10'b1001000100};
    tbl[3] = '{8'hA5, 10'b1101001010};
    tbl[4] = '{8'h00, 10'b1000000000};
    tbl[5] = '{8'hFF, 10'b1111111110};
    tbl[6] = '{8'h80, 10'b1100000000};
    tbl[7] = '{8'h01, 10'b1000000010};

    #2 reset = 1'b1;
    #20;
    chk("reset_tx", {29'd0, tx_w}, 32'd7);
    chk("reset_ready", {29'd0, ready_w}, 32'd7);
    chk("reset_idle", {29'd0, idle_w}, 32'd7);
    @(negedge clk);
    reset = 1'b0;
    tick();
    tick();
    rst_done = 1'b1;

    // Single frames from the table on the default instance.
    for (int i = 0; i < 8; i++) begin
      fq.delete();
      rxq.delete();
      sent.delete();
      fq.push_back(tbl[i].frame);
      sent.push_back(tbl[i].din);
      push1(tbl[i].din);                                  // edge N
      chk("idle_at_push", {31'd0, idle_w[0]}, 32'd1);
      chk("ready_at_push", {31'd0, ready_w[0]}, 32'd1);
      tick();                                             // edge N+1
      chk("idle_fall", {31'd0, idle_w[0]}, 32'd0);
      chk("tx_before_start", {31'd0, tx_w[0]}, 32'd1);
      tick();                                             // edge N+2
      check_wave(0, 10, 1, -1, 8'h00);
      wait_all_idle(300);
      chk_rx("tbl_rx");
    end

    // Three bytes on consecutive edges: 300 contiguous frame cycles.
    fq.delete();
    rxq.delete();
    sent = '{8'h11, 8'h22, 8'h44};
    foreach (sent[i]) fq.push_back(frame_of(sent[i]));
    dataIsValid = 1'b1;
    data = 8'h11; tick();
    data = 8'h22; tick();
    data = 8'h44; tick();
    dataIsValid = 1'b0;
    check_wave(0, 10, 1, -1, 8'h00);
    wait_all_idle(600);
    chk_rx("b2b_rx");

    // Byte arrives during the stop bit of an otherwise-last frame.
    fq.delete();
    rxq.delete();
    sent = '{8'h3C, 8'hC3};
    foreach (sent[i]) fq.push_back(frame_of(sent[i]));
    push1(8'h3C);
    tick();
    tick();
    check_wave(0, 10, 1, 96, 8'hC3);
    wait_all_idle(600);
    chk_rx("late_rx");

    // Overflow: strobe held for 8 edges while idle.
    rxq.delete();
    sent = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    dataIsValid = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      data = 8'(e);
      chk($sformatf("ovf_ready_edge%0d", e), {31'd0, ready_w[0]}, (e <= 5) ? 32'd1 : 32'd0);
      tick();
    end
    dataIsValid = 1'b0;
    wait_all_idle(900);
    chk_rx("ovf_rx");

    // 2 stop bits: 0xFF then 0x00, second start exactly 110 cycles later.
    fq.delete();
    fq.push_back(frame_of(8'hFF));
    fq.push_back(frame_of(8'h00));
    dataIsValid = 1'b1;
    data = 8'hFF; tick();
    data = 8'h00; tick();
    dataIsValid = 1'b0;
    tick();
    check_wave(1, 10, 2, -1, 8'h00);
    wait_all_idle(600);

    // 5 clocks per bit.
    fq.delete();
    fq.push_back(frame_of(8'h5A));
    push1(8'h5A);
    tick();
    tick();
    check_wave(2, 5, 1, -1, 8'h00);
    wait_all_idle(300);

    // Randomised traffic against the ordered-delivery model.
    rxq.delete();
    sent.delete();
    for (int i = 0; i < 16; i++) begin
      int w;
      logic [7:0] b;
      repeat ($urandom_range(0, 120)) tick();
      w = 0;
      while (!ready_w[0] && w < 400) begin
        tick();
        w++;
      end
      chk("rnd_ready_wait", {31'd0, ready_w[0]}, 32'd1);
      b = 8'($urandom);
      sent.push_back(b);
      push1(b);
    end
    wait_all_idle(3000);
    chk_rx("rnd_rx");

    // Reset during data bit 3 of 0xA5.
    push1(8'hA5);                                         // edge N
    tick();                                               // edge N+1
    repeat (45) tick();                                   // edge N+46: slot 4
    chk("rst_pre_tx", {31'd0, tx_w[0]}, {31'd0, frame_of(8'hA5)[4]});
    #2 reset = 1'b1;
    #1;
    chk("rst_async_tx", {29'd0, tx_w}, 32'd7);
    chk("rst_async_idle", {29'd0, idle_w}, 32'd7);
    chk("rst_async_ready", {29'd0, ready_w}, 32'd7);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (k % 25 == 0) begin
        chk("post_rst_tx", {29'd0, tx_w}, 32'd7);
        chk("post_rst_idle", {29'd0, idle_w}, 32'd7);
      end
    end
    rxq.delete();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_byte_tx.md
# uart_byte_tx

Single-clock UART transmitter with a built-in baud divider and a small byte FIFO. It is the transmit-side counterpart of `UartRx`: both blocks take the same `BAUD_RATE`/`CLOCK_RATE` parameters and share the system `clk`, so a design can loop `tx` straight into `UartRx.rx`. Upstream logic pushes bytes with a strobe/ready handshake. The block serialises them as 8N1-style frames (configurable stop bits), LSB first, with no gaps between queued frames.

## Interface
Parameters:
- `CLOCK_RATE`, default 100_000: system clock frequency in Hz.
- `BAUD_RATE`, default 9600: line rate in bit/s.
- `STOP_BITS`, default 1: number of stop bits per frame, 1 or 2.
- `FIFO_DEPTH`, default 4: byte FIFO entries; power of two, ≥ 2.

Ports:
- `clk` in 1: system clock, rising-edge. One clock domain; reset is asynchronous and active-high.
- `reset` in 1: asynchronous, active-high. Clears all state immediately.
- `data` in 8: byte to transmit.
- `dataIsValid` in 1: push strobe. `data` is accepted on any rising edge where `dataIsValid && ready`.
- `ready` out 1: FIFO not full.
- `tx` out 1: serial line, idle high.
- `idle` out 1: high when the FIFO is empty and no frame is in flight.

## Operation
- `CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE`, computed with integer truncation; 100_000/9600 gives 10. Elaboration fails if the result is below 2.
- Reset values: `tx`=1, `ready`=1, `idle`=1. FIFO is emptied, state is IDLE, all counters are 0.
- FIFO:
  - A push occurs when `dataIsValid && ready`. A strobe while `ready`=0 is ignored and the byte is dropped.
  - `ready` = count < `FIFO_DEPTH`, decoded from registered count.
  - A push and a pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- State machine (IDLE, START, DATA, STOP):
  - IDLE: `tx`=1. If the FIFO is non-empty, pop into a shift register, clear the bit timer, go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `tx` = shift[0] for `CLKS_PER_BIT` cycles, then shift right. After bit index 7, go to STOP.
  - STOP: `tx`=1 for `STOP_BITS*CLKS_PER_BIT` cycles. On the final cycle:
    - if the FIFO is non-empty, pop and go directly to START, so there is no idle gap;
    - otherwise go to IDLE.
- `idle` = (state==IDLE) && FIFO empty, registered.
- Reset mid-frame: `tx` returns to 1 asynchronously and the partial frame is abandoned. No resume.
- `tx` is driven from a flop so it is glitch-free.

## Timing
- Latency when idle with an empty FIFO:
  - Byte accepted at edge N.
  - Pop at edge N+1.
  - `tx` falls at edge N+2.
  - `idle` falls at edge N+1.
- Frame length: exactly `(9+STOP_BITS)*CLKS_PER_BIT` cycles. That is 100 cycles at the defaults.
- Back-to-back frames: the next start bit begins on the edge directly after the last stop-bit cycle.
- `idle` rises on the edge after the last stop-bit cycle if nothing is queued.
- A byte pushed while the FIFO is empty and a frame is in STOP is sent with no gap, provided it lands at least 1 cycle before the final stop cycle.

## Structure
- Package `uart_pkg` holds:
  - the `uart_tx_state_t` enum (IDLE, START, DATA, STOP);
  - a function `clks_per_bit(clockRate, baudRate)`;
  - the constant `UART_DATA_BITS = 8`.
  - `UartRx` imports the same package for its divider.
- Sub-module `byte_fifo` (parameter `DEPTH`; ports push, pop, din, dout, full, empty) is instantiated once. Read data is combinational from the head entry.

## Test plan
- Single byte with defaults: push 0x44 at edge 10. Required:
  - `tx` low from edge 12;
  - `tx` sequence over 10-cycle bits is 0, 0,0,1,0,0,0,1,0, then 1;
  - `idle` high again at edge 112.
- Three bytes 0x11, 0x22, 0x44 pushed on consecutive edges. Required: 300 contiguous cycles of frames with no high gap between the stop and start bits; `UartRx` looped back reports 0x11, 0x22, 0x44 in order.
- Overflow: hold `dataIsValid` high for 8 edges with bytes 0x01..0x08 while idle. Required:
  - exactly 0x01..0x05 accepted (1 popped, 4 stored);
  - `ready` low from the 6th edge;
  - 5 frames emitted.
- Reset mid-frame: assert `reset` during DATA bit 3 of 0xA5. Required: `tx`=1 asynchronously, `idle`=1, `ready`=1, and no further frames after release.
- `STOP_BITS`=2 with 0xFF: frame is one low bit, then 8 high bits, then 2 high bits. The next queued byte's start bit comes exactly 110 cycles after the first start bit.
- `CLOCK_RATE`=50_000, `BAUD_RATE`=9600: `CLKS_PER_BIT`=5 and every bit holds for exactly 5 cycles.
